// File: rtl/tff_sync_upcounter_pkg.sv
// Shared types and helpers for the T-flop synchronous up counter.
// The count type depends on a module parameter, so it is provided as a macro.
`define TFF_CNT_T(W) logic [(W)-1:0]

package tff_sync_upcounter_pkg;

    // Next-state select, in decreasing priority: RESET > LOAD > WRAP/COUNT > IDLE
    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        WRAP,
        LOAD,
        RESET
    } sel_e;

    function automatic int cnt_max(input int modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/tff_sync.sv
// Single T flip-flop without its own reset; the parent clears it by toggling set bits.
module tff_sync (
    input  logic clk,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        q <= q ^ t;
    end

endmodule

// File: rtl/tff_sync_upcounter.sv
// Synchronous modulo-MODULUS up counter: WIDTH T flops driven by a toggle-enable decoder,
// plus a sticky wrap flag and combinational terminal-count / carry-out for cascading.
module tff_sync_upcounter
    import tff_sync_upcounter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             co,
    output logic             ovf
);

    typedef `TFF_CNT_T(WIDTH) cnt_t;

    localparam cnt_t CNT_MAX = cnt_t'(cnt_max(MODULUS));

    if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_params
        $error("tff_sync_upcounter: need WIDTH>=1 and 2<=MODULUS<=2**WIDTH");
    end

    sel_e sel;
    cnt_t t;
    cnt_t ld_v;
    logic carry;
    logic ovf_q, ovf_d;

    always_comb begin
        sel = IDLE;
        if (rst)
            sel = RESET;
        else if (load)
            sel = LOAD;
        else if (en)
            sel = (q == CNT_MAX) ? WRAP : COUNT;
    end

    // Out-of-range load values collapse to 0 so q stays inside the modulus.
    always_comb begin
        ld_v  = ({1'b0, load_val} < (WIDTH+1)'(MODULUS)) ? load_val : '0;
        t     = '0;
        carry = 1'b1;
        unique case (sel)
            RESET: t = q;
            LOAD:  t = q ^ ld_v;
            WRAP:  t = q;
            COUNT: begin
                for (int i = 0; i < WIDTH; i++) begin
                    t[i]  = carry;
                    carry = carry & q[i];
                end
            end
            default: t = '0;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_sync u_tff (
            .clk (clk),
            .t   (t[i]),
            .q   (q[i])
        );
    end

    // A wrap on the same edge as clr_ovf leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (sel == WRAP)
            ovf_d = 1'b1;
        else if (clr_ovf)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
    assign tc  = (q == CNT_MAX);
    assign co  = tc & en & ~load & ~rst;

endmodule

// File: tb/tb_tff_sync_upcounter.sv
// Directed and model-checked bench for tff_sync_upcounter (mod-8, mod-6 and a 2-stage cascade).
module tb_tff_sync_upcounter;

    logic       clk = 1'b0;
    logic       rst, en, load, clr_ovf;
    logic [2:0] load_val;

    logic [2:0] q8, q6, qa, qb;
    logic       tc8, co8, ovf8, tc6, co6, ovf6, tca, coa, ovfa, tcb, cob, ovfb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tff_sync_upcounter #(.WIDTH(3), .MODULUS(8)) u_m8 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .q(q8), .tc(tc8), .co(co8), .ovf(ovf8));

    tff_sync_upcounter #(.WIDTH(3), .MODULUS(6)) u_m6 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .q(q6), .tc(tc6), .co(co6), .ovf(ovf6));

    tff_sync_upcounter #(.WIDTH(3), .MODULUS(8)) u_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .q(qa), .tc(tca), .co(coa), .ovf(ovfa));

    tff_sync_upcounter #(.WIDTH(3), .MODULUS(8)) u_b (
        .clk(clk), .rst(rst), .en(coa), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .q(qb), .tc(tcb), .co(cob), .ovf(ovfb));

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic l, input logic [2:0] lv, input logic c);
        rst = r; en = e; load = l; load_val = lv; clr_ovf = c;
    endtask

    // Behavioural reference: integer increment modulo m, flag updates by priority.
    task automatic mdl(input int m, inout int mq, inout bit mo);
        bit wrap;
        wrap = !rst && !load && en && (mq == m - 1);
        if (rst)       begin mq = 0; mo = 0; end
        else if (load) mq = (int'(load_val) < m) ? int'(load_val) : 0;
        else if (en)   mq = (mq == m - 1) ? 0 : mq + 1;
        if (!rst) begin
            if (wrap)         mo = 1;
            else if (clr_ovf) mo = 0;
        end
    endtask

    initial begin
        int m8q, m6q;
        bit m8o, m6o;

        // 1: mod-8 reset then free count
        drive(1, 0, 0, 0, 0);
        step(); step();
        chk("rst_q8", q8, 0);
        chk("rst_ovf8", ovf8, 0);
        chk("rst_q6", q6, 0);
        drive(0, 1, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("m8_q_%0d", k), q8, k % 8);
            chk($sformatf("m8_tc_%0d", k), tc8, (k % 8) == 7);
            chk($sformatf("m8_co_%0d", k), co8, (k % 8) == 7);
            chk($sformatf("m8_ovf_%0d", k), ovf8, k >= 8);
            step();
        end
        chk("m8_end_q", q8, 2);

        // 2: mod-6 count, then out-of-range load
        drive(1, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("m6_q_%0d", k), q6, k % 6);
            chk($sformatf("m6_range_%0d", k), q6 < 6, 1);
            step();
        end
        chk("m6_q_after8", q6, 2);
        chk("m6_ovf_after8", ovf6, 1);
        drive(0, 0, 1, 7, 0);
        step();
        chk("m6_ld7_q", q6, 0);
        chk("m6_ld7_ovf", ovf6, 1);

        // 3: load beats wrap, clr clears; wrap beats clr
        drive(0, 0, 1, 5, 0);
        step();
        chk("m6_ld5_q", q6, 5);
        drive(0, 1, 1, 2, 1);
        chk("m6_ldwrap_co", co6, 0);
        chk("m6_ldwrap_tc", tc6, 1);
        step();
        chk("m6_ldwrap_q", q6, 2);
        chk("m6_ldwrap_ovf", ovf6, 0);
        drive(0, 1, 0, 0, 0);
        step(); step(); step();
        chk("m6_at5_q", q6, 5);
        clr_ovf = 1;
        chk("m6_at5_co", co6, 1);
        step();
        chk("m6_wrapclr_q", q6, 0);
        chk("m6_wrapclr_ovf", ovf6, 1);
        drive(0, 0, 0, 0, 1);
        step();
        chk("m6_clr_ovf", ovf6, 0);

        // 4: reset beats load and enable
        drive(0, 0, 1, 4, 0);
        step();
        chk("m6_ld4_q", q6, 4);
        drive(1, 1, 1, 3, 0);
        chk("m6_rst_co", co6, 0);
        step();
        chk("m6_rstall_q", q6, 0);
        chk("m6_rstall_ovf", ovf6, 0);
        drive(0, 1, 0, 0, 0);
        step();
        chk("m6_postrst_q", q6, 1);

        // 5: two mod-8 stages cascaded through co
        drive(1, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 0);
        for (int k = 0; k < 70; k++) begin
            chk($sformatf("casc_q_%0d", k), {qb, qa}, k % 64);
            chk($sformatf("casc_ovfb_%0d", k), ovfb, k >= 64);
            step();
        end

        // 6: random stimulus against the reference model
        drive(1, 0, 0, 0, 0);
        step();
        m8q = 0; m6q = 0; m8o = 0; m6o = 0;
        for (int k = 0; k < 2000; k++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0);
            #1;
            chk("rnd_q8", q8, m8q);
            chk("rnd_ovf8", ovf8, m8o);
            chk("rnd_co8", co8, (m8q == 7) && en && !load && !rst);
            chk("rnd_q6", q6, m6q);
            chk("rnd_ovf6", ovf6, m6o);
            chk("rnd_tc6", tc6, m6q == 5);
            chk("rnd_co6", co6, (m6q == 5) && en && !load && !rst);
            chk("rnd_range6", q6 < 6, 1);
            mdl(8, m8q, m8o);
            mdl(6, m6q, m6o);
            step();
        end
        chk("rnd_final_q8", q8, m8q);
        chk("rnd_final_q6", q6, m6q);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tff_sync_upcounter.md
Name: tff_sync_upcounter

Overview:
- Synchronous modulo-N up counter built from per-bit T flip-flops, all clocked by one common clock.
- Counterpart of the team's asynchronous ripple down counter: same T-flop style, opposite count direction, single clock domain.
- Used wherever a glitch-free, loadable, cascadable up count is needed (event counters, prescalers, divider chains).

Parameters:
- WIDTH, 3, counter width in bits; minimum 1.
- MODULUS, 8, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  sole clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; counts one step per cycle while high.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value captured when load=1.
- clr_ovf  input  1  clears the sticky overflow flag.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count, combinational: q == MODULUS-1, not gated by en.
- co  output  1  carry out, combinational: tc & en & ~load & ~rst; drives en of the next stage.
- ovf  output  1  sticky wrap flag (registered).

Behaviour:
- Interface:
  - One clock.
  - Reset is synchronous and active-high.
  - Ports are named clk and rst.
- Reset: on a clk edge with rst=1, q=0 and ovf=0. rst has priority over every other input. No asynchronous path exists.
- Priority per edge is rst > load > en. With en=0 and load=0, q holds.
- Every bit of q is a T flip-flop. All next-state logic is expressed as per-bit toggle enables t[i], evaluated at posedge clk (q_next = q ^ t):
  - Reset: t = q.
  - Load: t = q ^ v, where v = load_val if load_val < MODULUS, else 0. Out-of-range loads give q=0 and do not set ovf.
  - Count, q < MODULUS-1: t[0]=1; t[i] = &q[i-1:0] for i>0 (binary increment).
  - Count, q == MODULUS-1: t = q, so q wraps to 0.
  - Idle: t = 0.
- Latency:
  - q updates 1 cycle after en, load or rst is sampled.
  - tc and co follow q combinationally, with 0 extra cycles.
- Overflow:
  - ovf is set on the edge where a count-wrap occurs (en=1, load=0, rst=0, q == MODULUS-1).
  - clr_ovf=1 clears ovf on the next edge.
  - Wrap and clr_ovf on the same edge: set wins, so ovf=1.
  - load does not affect ovf.
- Load on the wrap cycle: load wins. No wrap occurs and ovf is not set.
- When MODULUS == 2**WIDTH, the wrap and increment paths produce the same value. Both paths remain in the RTL; no special casing.
- Reset mid-count: q=0 on the next edge. In-flight load or en is discarded.
- q never holds a value >= MODULUS after any edge. The verifier asserts this as a property.

Decomposition:
- Shared counter package:
  - Typedef cnt_t (logic [WIDTH-1:0]) via a parameterised macro or class.
  - Constant CNT_MAX = MODULUS-1.
  - Enum for the next-state select: IDLE, COUNT, WRAP, LOAD, RESET.
- Sub-module tff_sync: a 1-bit T flip-flop (clk, t, q) with no reset of its own. It is instantiated WIDTH times via generate; reset is folded into t.
- Top level holds the toggle-decode logic, the ovf register and the tc/co logic.

Test Plan:
1. WIDTH=3, MODULUS=8: rst=1 for 2 cycles, then en=1 for 10 cycles.
   - q goes 0,1,...,7,0,1,2.
   - tc=1 only at q=7; co=1 on that cycle.
   - ovf=1 from the edge after q=7 onward.
2. WIDTH=3, MODULUS=6: en=1 for 8 cycles.
   - q goes 0..5,0,1 and never reaches 6 or 7.
   - Then load=1, load_val=7: q=0, ovf unchanged.
3. At q=5 with en=1, drive load=1, load_val=2 and clr_ovf=1 together.
   - q=2, no wrap, ovf=0.
   - On the wrap cycle, drive clr_ovf=1 again: ovf=1 (set wins).
4. q=4 with en=1, rst=1, load=1, load_val=3 on one edge.
   - q=0, ovf=0.
   - Next cycle, rst=0 with en held high: q=1.
5. Two instances cascaded (co of stage A to en of stage B), MODULUS=8 each, en=1 for 70 cycles.
   - {B.q, A.q} counts 0..63 then wraps.
   - B.ovf=1 only after cycle 64.
6. Random en/load/clr_ovf for 2000 cycles against a reference model.
   - q matches every cycle.
   - q < MODULUS is always true.
